// File: rtl/bcd_digit_feeder.sv
// ---------------------------------------------------------------------------
// bcd_digit_feeder
//
// Purpose:
//   Upstream feeder for the on-screen seven-segment digit drawers. It turns a
//   binary game counter into DIGITS packed BCD digits using the iterative
//   shift-add-3 (double dabble) algorithm, one bit per clock. The finished
//   value is parked in a shadow register. It is copied to the displayed
//   digits only on a frame_start strobe, so the drawers never see a digit
//   change in the middle of a scan.
//
// Ports:
//   clk_50      - pixel-domain clock, shared with the VGA timing counters
//   reset_n     - asynchronous, active-low reset
//   bin_in      - binary value to display, sampled when a conversion starts
//   load        - single-cycle request to convert bin_in
//   frame_start - single-cycle strobe at the start of vertical blank
//   busy        - conversion in progress (CONVERT or COMMIT)
//   digits_out  - displayed BCD digits; digit k occupies [4k+3:4k]
//   digit_en    - per-digit draw enable
//   updated     - one-cycle pulse when digits_out has just been refreshed
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   When defined, digit_en is recomputed from the value copied to digits_out.
//   Leading zero digits are blanked, and digit 0 always stays enabled. When
//   undefined, digit_en is constant all ones.
// ---------------------------------------------------------------------------
module bcd_digit_feeder #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk_50,
  input  logic                  reset_n,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  input  logic                  load,
  input  logic                  frame_start,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  updated
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_WIDTH;
  localparam int CNT_W  = $clog2(BIN_WIDTH + 1);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  // Largest value that DIGITS decimal digits can hold (10^DIGITS - 1).
  function automatic logic [63:0] max_bcd_value(input int num_digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < num_digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_bcd_value(DIGITS);

  // One double-dabble iteration: correct every BCD nibble that is >= 5, then
  // shift the whole {bcd, bin} register left so the next binary bit enters
  // the BCD field.
  function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] r);
    logic [WORK_W-1:0] t;
    t = r;
    for (int k = 0; k < DIGITS; k++) begin
      if (t[BIN_WIDTH + 4*k +: 4] >= 4'd5) begin
        t[BIN_WIDTH + 4*k +: 4] = t[BIN_WIDTH + 4*k +: 4] + 4'd3;
      end
    end
    return t << 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t                state;
  state_t                next_state;

  logic [WORK_W-1:0]     work;
  logic [CNT_W-1:0]      iter;
  logic                  sat;
  logic [BCD_W-1:0]      shadow;
  logic                  pending;
  logic                  buf_valid;
  logic [BIN_WIDTH-1:0]  buf_val;

  logic                  start;
  logic                  commit;
  logic [BIN_WIDTH-1:0]  start_value;
  logic                  start_sat;
  logic                  frame_update;

  // A buffered request always takes priority over a fresh load.
  assign start_value = buf_valid ? buf_val : bin_in;
  assign start_sat   = 64'(start_value) > MAX_VAL;

  // A frame only refreshes the display when there is something new waiting.
  assign frame_update = frame_start && pending;

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state logic. COMMIT chains straight into a new conversion
  // when a request was buffered while the previous one was running.
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (buf_valid || load) begin
          next_state = CONVERT;
        end
      end
      CONVERT: begin
        if (iter == LAST_ITER) begin
          next_state = COMMIT;
        end
      end
      COMMIT: begin
        next_state = buf_valid ? CONVERT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM outputs. start fires whenever a new conversion is launched, either
  // from IDLE or directly out of COMMIT.
  // ---------------------------------------------------------------------
  always_comb begin
    busy   = 1'b0;
    commit = 1'b0;
    start  = 1'b0;
    unique case (state)
      IDLE: begin
        start = buf_valid || load;
      end
      CONVERT: begin
        busy = 1'b1;
      end
      COMMIT: begin
        busy   = 1'b1;
        commit = 1'b1;
        start  = buf_valid;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Conversion datapath: the {bcd, bin} work register and iteration count.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      work <= '0;
      iter <= '0;
      sat  <= 1'b0;
    end else if (start) begin
      work <= {{BCD_W{1'b0}}, start_value};
      iter <= '0;
      sat  <= start_sat;
    end else if (state == CONVERT) begin
      work <= dabble_step(work);
      iter <= iter + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // One-deep request buffer. Any load that cannot start a conversion right
  // away lands here, and the most recent one wins. When the buffer is
  // drained in the same cycle as a new load, the load refills it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid <= 1'b0;
      buf_val   <= '0;
    end else if (load && (state != IDLE || buf_valid)) begin
      buf_valid <= 1'b1;
      buf_val   <= bin_in;
    end else if (start && buf_valid) begin
      buf_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Shadow register and pending flag. A commit that coincides with a frame
  // keeps pending set, so the frame shows the older shadow value and the
  // new one waits for the following frame.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else if (commit) begin
      shadow  <= sat ? ALL_NINES : work[WORK_W-1 -: BCD_W];
      pending <= 1'b1;
    end else if (frame_update) begin
      pending <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Displayed digits and the update pulse, refreshed only at a frame edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      digits_out <= '0;
      updated    <= 1'b0;
    end else begin
      updated <= frame_update;
      if (frame_update) begin
        digits_out <= shadow;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Enable every digit from the most significant non-zero one downwards.
  // Digit 0 is forced on so a value of zero still draws a single "0".
  function automatic logic [DIGITS-1:0] lead_mask(input logic [BCD_W-1:0] d);
    logic [DIGITS-1:0] m;
    logic              seen;
    m    = '0;
    seen = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (d[4*k +: 4] != 4'h0) begin
        seen = 1'b1;
      end
      m[k] = seen || (k == 0);
    end
    return m;
  endfunction

  // Draw enables follow the digits, so both change on the same frame edge.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      digit_en <= '1;
    end else if (frame_update) begin
      digit_en <= lead_mask(shadow);
    end
  end
`else
  assign digit_en = '1;
`endif

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_feeder
//
// Purpose:
//   Self-checking bench for bcd_digit_feeder at the default parameters.
//   Expected digits come from plain decimal arithmetic on the loaded value.
//   The bench tracks which value should currently be on screen and checks
//   the double-buffered frame behaviour, the one-deep request buffer, a
//   reset during conversion, and randomised values.
// ---------------------------------------------------------------------------
module tb_bcd_digit_feeder;

  localparam int BW      = 16;
  localparam int DG      = 5;
  localparam int LATENCY = BW + 1;
  localparam int TIMEOUT = 200;

  logic            clk_50;
  logic            reset_n;
  logic [BW-1:0]   bin_in;
  logic            load;
  logic            frame_start;
  logic            busy;
  logic [4*DG-1:0] digits_out;
  logic [DG-1:0]   digit_en;
  logic            updated;

  int passed;
  int total;

  // Value that should currently be displayed, plus the enables that go with it.
  logic [4*DG-1:0] shown;
  logic [DG-1:0]   shown_en;

  bcd_digit_feeder #(
    .BIN_WIDTH(BW),
    .DIGITS   (DG)
  ) dut (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .bin_in     (bin_in),
    .load       (load),
    .frame_start(frame_start),
    .busy       (busy),
    .digits_out (digits_out),
    .digit_en   (digit_en),
    .updated    (updated)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  // Decimal digits of v, saturated to all nines when v does not fit.
  function automatic logic [4*DG-1:0] ref_bcd(input longint v);
    logic [4*DG-1:0] r;
    longint          p;
    longint          maxv;
    maxv = 1;
    for (int k = 0; k < DG; k++) maxv = maxv * 10;
    maxv = maxv - 1;
    if (v > maxv) v = maxv;
    r = '0;
    p = 1;
    for (int k = 0; k < DG; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Expected draw enables for a displayed value v.
  function automatic logic [DG-1:0] ref_en(input longint v);
`ifdef LEADING_ZERO_BLANK_EN
    int     n;
    longint p;
    n = 1;
    p = 10;
    while (n < DG && v >= p) begin
      n++;
      p = p * 10;
    end
    return DG'((1 << n) - 1);
`else
    return {DG{1'b1}} | DG'(v & 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  // Pulse load for one cycle. The load is sampled at the edge inside tick.
  task automatic applyStimulus(input logic [BW-1:0] v);
    bin_in = v;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  // Count cycles with busy high, starting just after the load edge.
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < TIMEOUT) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    load        = 1'b0;
    frame_start = 1'b0;
    bin_in      = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    shown    = '0;
    shown_en = {DG{1'b1}};
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (updated !== 1'b0) $display("[TB] FAIL reset_updated: got %b expected 0", updated); else passed++;
    total++; if (digits_out !== '0) $display("[TB] FAIL reset_digits: got %h expected 0", digits_out); else passed++;
    total++; if (digit_en !== {DG{1'b1}}) $display("[TB] FAIL reset_en: got %b expected %b", digit_en, {DG{1'b1}}); else passed++;
  endtask

  task automatic test_basic_10545();
    int cycles;
    applyStimulus(16'd10545);
    count_busy(cycles);
    total++; if (cycles != LATENCY) $display("[TB] FAIL basic_busy_len: got %0d expected %0d", cycles, LATENCY); else passed++;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    shown    = ref_bcd(10545);
    shown_en = ref_en(10545);
    total++; if (updated !== 1'b1) $display("[TB] FAIL basic_updated: got %b expected 1", updated); else passed++;
    total++; if (digits_out !== shown) $display("[TB] FAIL basic_digits: got %h expected %h", digits_out, shown); else passed++;
    total++; if (digit_en !== shown_en) $display("[TB] FAIL basic_en: got %b expected %b", digit_en, shown_en); else passed++;
    tick();
    total++; if (updated !== 1'b0) $display("[TB] FAIL basic_updated_once: got %b expected 0", updated); else passed++;
  endtask

  task automatic test_early_frame();
    int cycles;
    applyStimulus(16'd65535);
    repeat (5) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    total++; if (updated !== 1'b0) $display("[TB] FAIL early_updated: got %b expected 0", updated); else passed++;
    total++; if (digits_out !== shown) $display("[TB] FAIL early_digits: got %h expected %h", digits_out, shown); else passed++;
    count_busy(cycles);
    total++; if (cycles >= TIMEOUT) $display("[TB] FAIL early_busy_timeout: got %0d expected below %0d", cycles, TIMEOUT); else passed++;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    shown    = ref_bcd(65535);
    shown_en = ref_en(65535);
    total++; if (updated !== 1'b1) $display("[TB] FAIL early_next_updated: got %b expected 1", updated); else passed++;
    total++; if (digits_out !== shown) $display("[TB] FAIL early_next_digits: got %h expected %h", digits_out, shown); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int cycles;
    int seen42;
    seen42 = 0;
    applyStimulus(16'd123);
    for (int c = 1; c <= 19; c++) begin
      if (c == 3) begin
        bin_in = 16'd42;
        load   = 1'b1;
      end else if (c == 5) begin
        bin_in = 16'd7;
        load   = 1'b1;
      end
      tick();
      load = 1'b0;
      if (digits_out === ref_bcd(42)) seen42++;
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    shown    = ref_bcd(123);
    shown_en = ref_en(123);
    total++; if (digits_out !== shown) $display("[TB] FAIL b2b_first_digits: got %h expected %h", digits_out, shown); else passed++;
    total++; if (digit_en !== shown_en) $display("[TB] FAIL b2b_first_en: got %b expected %b", digit_en, shown_en); else passed++;
    total++; if (busy !== 1'b1) $display("[TB] FAIL b2b_chained_busy: got %b expected 1", busy); else passed++;
    cycles = 0;
    while (busy === 1'b1 && cycles < TIMEOUT) begin
      cycles++;
      tick();
      if (digits_out === ref_bcd(42)) seen42++;
    end
    total++; if (cycles >= TIMEOUT) $display("[TB] FAIL b2b_busy_timeout: got %0d expected below %0d", cycles, TIMEOUT); else passed++;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    shown    = ref_bcd(7);
    shown_en = ref_en(7);
    total++; if (digits_out !== shown) $display("[TB] FAIL b2b_second_digits: got %h expected %h", digits_out, shown); else passed++;
    total++; if (digit_en !== shown_en) $display("[TB] FAIL b2b_second_en: got %b expected %b", digit_en, shown_en); else passed++;
    repeat (4) begin
      tick();
      if (digits_out === ref_bcd(42)) seen42++;
    end
    total++; if (seen42 != 0) $display("[TB] FAIL b2b_overwritten_shown: got %0d cycles expected 0", seen42); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL b2b_no_extra_conv: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_commit_frame_coincident();
    applyStimulus(16'd4096);
    repeat (LATENCY - 1) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    total++; if (updated !== 1'b0) $display("[TB] FAIL coinc_updated: got %b expected 0", updated); else passed++;
    total++; if (digits_out !== shown) $display("[TB] FAIL coinc_digits: got %h expected %h", digits_out, shown); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL coinc_busy: got %b expected 0", busy); else passed++;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    shown    = ref_bcd(4096);
    shown_en = ref_en(4096);
    total++; if (updated !== 1'b1) $display("[TB] FAIL coinc_next_updated: got %b expected 1", updated); else passed++;
    total++; if (digits_out !== shown) $display("[TB] FAIL coinc_next_digits: got %h expected %h", digits_out, shown); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_conversion();
    int cycles;
    applyStimulus(16'd555);
    count_busy(cycles);
    applyStimulus(16'd999);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin
        bin_in = 16'd31;
        load   = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    shown    = '0;
    shown_en = {DG{1'b1}};
    total++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); else passed++;
    total++; if (digits_out !== '0) $display("[TB] FAIL rstmid_digits: got %h expected 0", digits_out); else passed++;
    total++; if (digit_en !== {DG{1'b1}}) $display("[TB] FAIL rstmid_en: got %b expected %b", digit_en, {DG{1'b1}}); else passed++;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_buffer_dropped: got %b expected 0", busy); else passed++;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    total++; if (updated !== 1'b0) $display("[TB] FAIL rstmid_frame_updated: got %b expected 0", updated); else passed++;
    total++; if (digits_out !== '0) $display("[TB] FAIL rstmid_frame_digits: got %h expected 0", digits_out); else passed++;
  endtask

  task automatic test_random_values();
    int            cycles;
    logic [BW-1:0] v;
    logic [BW-1:0] table_vals [8];
    table_vals = '{16'd0, 16'd7, 16'd300, 16'd9, 16'd10, 16'd99, 16'd1000, 16'd65535};
    for (int i = 0; i < 16; i++) begin
      if (i < 8) v = table_vals[i];
      else       v = BW'($urandom_range(0, 65535));
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(v);
      count_busy(cycles);
      total++; if (cycles != LATENCY) $display("[TB] FAIL rand_busy_len[%0d]: got %0d expected %0d", v, cycles, LATENCY); else passed++;
      repeat ($urandom_range(0, 3)) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      shown    = ref_bcd(longint'(v));
      shown_en = ref_en(longint'(v));
      total++; if (updated !== 1'b1) $display("[TB] FAIL rand_updated[%0d]: got %b expected 1", v, updated); else passed++;
      total++; if (digits_out !== shown) $display("[TB] FAIL rand_digits[%0d]: got %h expected %h", v, digits_out, shown); else passed++;
      total++; if (digit_en !== shown_en) $display("[TB] FAIL rand_en[%0d]: got %b expected %b", v, digit_en, shown_en); else passed++;
      tick();
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic_10545();
    test_early_frame();
    test_back_to_back();
    test_commit_frame_coincident();
    test_reset_mid_conversion();
    test_random_values();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
